bounce_engine: RTL and testbench
================================

// Module: bounce_engine
// PURPOSE
//  Per-frame object motion generator, upstream of screen_gen. Watches VSYNC from the
//  vga timing block and advances one rectangle's top-left position once per frame,
//  reflecting it off the active-area edges. Outputs change only inside vertical
//  blanking, so screen_gen never draws a torn frame.
// PARAMETERS
//  H_ACTIVE         640  visible columns
//  V_ACTIVE         480  visible rows
//  OBJ_W            32   object width, pixels
//  OBJ_H            32   object height, pixels
//  SPEED_X          2    pixels moved per frame, horizontal
//  SPEED_Y          1    pixels moved per frame, vertical
//  START_X          304  reset column
//  START_Y          224  reset row
//  VSYNC_ACTIVE_LOW 1    1: VSYNC asserts low (640x480 timing); 0: asserts high
// PORTS
//  clk         in   1   pixel clock (PLL output domain)
//  reset       in   1   asynchronous reset, active-high
//  VSYNC       in   1   vertical sync from vga timing block, same clk domain
//  pause       in   1   1 = hold position; frames still counted
//  obj_x       out  10  committed object column (top-left)
//  obj_y       out  10  committed object row (top-left)
//  bounce      out  1   1-cycle pulse on commit if any wall was hit this frame
//  corner      out  1   1-cycle pulse on commit if X and Y walls both hit this frame
//  frame_count out  16  frames seen since reset; wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: obj_x=START_X, obj_y=START_Y, direction right+down, bounce=corner=0,
//   frame_count=0, FSM=IDLE, shadow x/y = START, vsync_q = asserted level.
//   Resetting vsync_q to the asserted level means a reset released mid-pulse
//   produces no false tick.
//  Tick: 1-cycle when VSYNC goes from deasserted to asserted (vsync_q vs VSYNC).
//  FSM: IDLE -tick-> UPD_X -> UPD_Y -> COMMIT -> IDLE; one state per cycle.
//   Tick at edge N: UPD_X at N+1, UPD_Y at N+2. At edge N+3, obj_x/obj_y, bounce
//   and corner update. frame_count increments at N+1.
//  Ticks arriving outside IDLE are ignored; they cannot occur at legal timing.
//  UPD_X, moving right:
//   if x >= H_ACTIVE-OBJ_W-SPEED_X then x=H_ACTIVE-OBJ_W, dir=left, hit_x=1
//   else x+=SPEED_X.
//  UPD_X, moving left:
//   if x <= SPEED_X then x=0, dir=right, hit_x=1
//   else x-=SPEED_X.
//  UPD_Y: same rules with V_ACTIVE, OBJ_H, SPEED_Y and directions down/up.
//  Comparisons use 11-bit unsigned math, so there is no underflow or wrap.
//  pause=1 at tick: UPD states leave x/y and dirs unchanged and hit flags are 0.
//   COMMIT still runs and frame_count still increments.
//  bounce = hit_x|hit_y; corner = hit_x&hit_y. Both are 0 outside the COMMIT edge.
//  obj_x/obj_y are registered and hold between commits. No combinational
//   input-to-output path.
//  Async reset mid-update: all state returns to reset values immediately and the
//   partial update is discarded.
// STRUCTURE
//  game_pkg: coord_t (logic [9:0]), H_ACTIVE/V_ACTIVE defaults, motion_state_e
//   {IDLE,UPD_X,UPD_Y,COMMIT}; shared with screen_gen.
//  Sub-module sync_edge_detect (params ACTIVE_LOW; ports clk, reset, sync_in,
//   tick): registers the sync and emits the assert-edge pulse. Reusable for HSYNC.
// TESTING
//  Reset: assert reset, VSYNC=1 -> obj_x=304, obj_y=224, frame_count=0,
//   bounce=corner=0; release reset with VSYNC=0 -> no tick, counter stays 0.
//  Free motion: 3 VSYNC pulses from reset -> obj_x=310, obj_y=227, frame_count=3.
//   Each update lands exactly 3 cycles after the falling edge.
//  Right wall: force x=607 moving right -> one frame gives x=608, bounce pulse,
//   then x=606 moving left. Left wall: x=2 -> x=0, bounce, then x=2.
//  Corner: x=608 moving right, y=447 moving down, one tick -> x=608, y=448,
//   corner=1, bounce=1; next tick x=606, y=447.
//  Pause: pause=1 across 5 ticks -> obj_x/obj_y unchanged, frame_count +5,
//   no bounce pulses.
//  Mid-update reset: assert reset one cycle after a tick (FSM in UPD_X) -> outputs
//   return to 304/224 asynchronously and the next post-reset tick moves by exactly
//   one step.

Source files
------------

// File: rtl/bounce_engine_pkg.sv
// -----------------------------------------------------------------------------
// bounce_engine_pkg
// Shared types for the motion generator and its consumers (screen_gen):
//   coord_t         10-bit screen coordinate
//   motion_state_e  per-frame update sequencer states
//   axis_step_t     result of moving one axis by one frame step
//   step_axis()     one-axis move with wall reflection, 11-bit unsigned math
// -----------------------------------------------------------------------------
package bounce_engine_pkg;

    typedef logic [9:0] coord_t;

    localparam int H_ACTIVE_DEFAULT = 640;
    localparam int V_ACTIVE_DEFAULT = 480;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPD_X  = 2'd1,
        UPD_Y  = 2'd2,
        COMMIT = 2'd3
    } motion_state_e;

    typedef struct packed {
        coord_t pos;
        logic   fwd;   // 1 = moving toward max_pos (right/down)
        logic   hit;   // wall reached on this step
    } axis_step_t;

    // Advance one axis by speed; clamp to the wall and reverse on contact.
    // Widened to 11 bits so max_pos - speed and pos + speed never wrap.
    function automatic axis_step_t step_axis(
        input coord_t      pos,
        input logic        fwd,
        input logic [10:0] max_pos,
        input logic [10:0] speed
    );
        axis_step_t  res;
        logic [10:0] pos_w;
        logic [10:0] nxt_w;
        pos_w = {1'b0, pos};
        nxt_w = 11'd0;
        res   = '{pos: pos, fwd: fwd, hit: 1'b0};
        if (fwd) begin
            if (pos_w >= max_pos - speed) begin
                res.pos = max_pos[9:0];
                res.fwd = 1'b0;
                res.hit = 1'b1;
            end else begin
                nxt_w   = pos_w + speed;
                res.pos = nxt_w[9:0];
            end
        end else begin
            if (pos_w <= speed) begin
                res.pos = 10'd0;
                res.fwd = 1'b1;
                res.hit = 1'b1;
            end else begin
                nxt_w   = pos_w - speed;
                res.pos = nxt_w[9:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bounce_engine_if.sv
// -----------------------------------------------------------------------------
// bounce_engine_if
// Bundles the timing input, control input and motion outputs of bounce_engine.
//   VSYNC, pause                         : driven by master (timing/control side)
//   obj_x, obj_y, bounce, corner,
//   frame_count                          : driven by slave (bounce_engine)
// -----------------------------------------------------------------------------
interface bounce_engine_if;
    import bounce_engine_pkg::*;

    logic        VSYNC;
    logic        pause;
    coord_t      obj_x;
    coord_t      obj_y;
    logic        bounce;
    logic        corner;
    logic [15:0] frame_count;

    modport master (
        output VSYNC, pause,
        input  obj_x, obj_y, bounce, corner, frame_count
    );

    modport slave (
        input  VSYNC, pause,
        output obj_x, obj_y, bounce, corner, frame_count
    );

endinterface

// File: rtl/bounce_engine_sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
// Registers a sync signal and pulses tick for one cycle on its assert edge.
//   ACTIVE_LOW  1: sync asserts low, 0: sync asserts high
//   clk         clock (same domain as sync_in)
//   reset       asynchronous, active-high
//   sync_in     raw sync level
//   tick        1-cycle pulse when sync_in becomes asserted
// The history register resets to the asserted level, so releasing reset in the
// middle of a sync pulse does not look like a fresh assert edge.
// -----------------------------------------------------------------------------
module sync_edge_detect #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic sync_in,
    output logic tick
);

    logic sync_q_r;

    // Previous-cycle sync level for edge comparison.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q_r <= ~ACTIVE_LOW;
        end else begin
            sync_q_r <= sync_in;
        end
    end

    // XOR with ACTIVE_LOW normalises both samples to "1 = asserted".
    assign tick = (sync_in ^ ACTIVE_LOW) & ~(sync_q_r ^ ACTIVE_LOW);

endmodule

// File: rtl/bounce_engine.sv
// -----------------------------------------------------------------------------
// bounce_engine
// Per-frame motion generator: on each VSYNC assert edge, steps one rectangle's
// top-left corner and reflects it off the active-area edges. New coordinates
// are committed three cycles after the edge, well inside vertical blanking.
//   clk    pixel clock
//   reset  asynchronous, active-high
//   bus    bounce_engine_if.slave: VSYNC, pause in; obj_x, obj_y, bounce,
//          corner, frame_count out (all outputs registered)
// -----------------------------------------------------------------------------
module bounce_engine
    import bounce_engine_pkg::*;
#(
    parameter int H_ACTIVE         = H_ACTIVE_DEFAULT,
    parameter int V_ACTIVE         = V_ACTIVE_DEFAULT,
    parameter int OBJ_W            = 32,
    parameter int OBJ_H            = 32,
    parameter int SPEED_X          = 2,
    parameter int SPEED_Y          = 1,
    parameter int START_X          = 304,
    parameter int START_Y          = 224,
    parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    bounce_engine_if.slave bus
);

    localparam logic [10:0] X_MAX   = 11'(H_ACTIVE - OBJ_W);
    localparam logic [10:0] Y_MAX   = 11'(V_ACTIVE - OBJ_H);
    localparam logic [10:0] SPD_X   = 11'(SPEED_X);
    localparam logic [10:0] SPD_Y   = 11'(SPEED_Y);
    localparam coord_t      X_START = 10'(START_X);
    localparam coord_t      Y_START = 10'(START_Y);

    motion_state_e state_r;
    logic          tick_s;
    logic          pause_r;
    coord_t        x_r;        // shadow position, built up during UPD states
    coord_t        y_r;
    logic          dir_x_r;    // 1 = right
    logic          dir_y_r;    // 1 = down
    logic          hit_x_r;
    logic          hit_y_r;
    coord_t        obj_x_r;
    coord_t        obj_y_r;
    logic          bounce_r;
    logic          corner_r;
    logic [15:0]   frame_count_r;
    axis_step_t    step_x_s;
    axis_step_t    step_y_s;

    sync_edge_detect #(
        .ACTIVE_LOW (VSYNC_ACTIVE_LOW)
    ) u_vsync_edge (
        .clk     (clk),
        .reset   (reset),
        .sync_in (bus.VSYNC),
        .tick    (tick_s)
    );

    assign step_x_s = step_axis(x_r, dir_x_r, X_MAX, SPD_X);
    assign step_y_s = step_axis(y_r, dir_y_r, Y_MAX, SPD_Y);

    // Frame update sequencer: IDLE -> UPD_X -> UPD_Y -> COMMIT -> IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            pause_r       <= 1'b0;
            x_r           <= X_START;
            y_r           <= Y_START;
            dir_x_r       <= 1'b1;
            dir_y_r       <= 1'b1;
            hit_x_r       <= 1'b0;
            hit_y_r       <= 1'b0;
            obj_x_r       <= X_START;
            obj_y_r       <= Y_START;
            bounce_r      <= 1'b0;
            corner_r      <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            // Pulses are only high for the single cycle after COMMIT.
            bounce_r <= 1'b0;
            corner_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (tick_s) begin
                        // pause is captured once so the whole frame agrees.
                        pause_r <= bus.pause;
                        state_r <= UPD_X;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                UPD_X: begin
                    frame_count_r <= frame_count_r + 16'd1;
                    if (pause_r) begin
                        hit_x_r <= 1'b0;
                    end else begin
                        x_r     <= step_x_s.pos;
                        dir_x_r <= step_x_s.fwd;
                        hit_x_r <= step_x_s.hit;
                    end
                    state_r <= UPD_Y;
                end
                UPD_Y: begin
                    if (pause_r) begin
                        hit_y_r <= 1'b0;
                    end else begin
                        y_r     <= step_y_s.pos;
                        dir_y_r <= step_y_s.fwd;
                        hit_y_r <= step_y_s.hit;
                    end
                    state_r <= COMMIT;
                end
                COMMIT: begin
                    obj_x_r  <= x_r;
                    obj_y_r  <= y_r;
                    bounce_r <= hit_x_r | hit_y_r;
                    corner_r <= hit_x_r & hit_y_r;
                    state_r  <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.obj_x       = obj_x_r;
    assign bus.obj_y       = obj_y_r;
    assign bus.bounce      = bounce_r;
    assign bus.corner      = corner_r;
    assign bus.frame_count = frame_count_r;

endmodule

// File: tb/tb_bounce_engine.sv
// -----------------------------------------------------------------------------
// tb_bounce_engine
// Self-checking bench for bounce_engine. A table of frame groups with known
// end positions, a randomized run against a triangle-wave position model,
// plus hand sequences for reset behaviour and a corner hit (second instance
// started against the bottom-right walls).
// -----------------------------------------------------------------------------
module tb_bounce_engine;
    import bounce_engine_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bounce_engine_if bif ();
    bounce_engine_if cif ();

    bounce_engine dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bif.slave)
    );

    bounce_engine #(
        .START_X (608),
        .START_Y (447)
    ) dut_c (
        .clk   (clk),
        .reset (rst),
        .bus   (cif.slave)
    );

    int vectors    = 0;
    int miscompares = 0;
    int n_model    = 0;   // unpaused frames since reset
    int fc_model   = 0;   // all frames since reset

    typedef struct {
        logic p;
        int   frames;
        int   ex;
        int   ey;
        int   efc;
        int   ebounces;
        logic eb;
        logic ec;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Unfolded straight-line travel reflected into [0, max]: a triangle wave.
    function automatic int tri_pos(input int start, input int speed, input int max, input int n);
        int p;
        int m;
        p = start + speed * n;
        m = p % (2 * max);
        return (m <= max) ? m : (2 * max - m);
    endfunction

    // One VSYNC pulse on the main DUT; returns bounce/corner seen at commit.
    task automatic run_frame(input logic p, input int low_len, input int gap,
                             output logic b, output logic c);
        logic [9:0] x0;
        logic [9:0] y0;
        int total;
        total = low_len + gap;
        if (total < 6) total = 6;
        b = 1'b0;
        c = 1'b0;
        @(negedge clk);
        x0 = bif.obj_x;
        y0 = bif.obj_y;
        bif.VSYNC = 1'b0;
        bif.pause = p;
        for (int i = 1; i <= total; i++) begin
            @(negedge clk);
            if (i == low_len) bif.VSYNC = 1'b1;
            if (i == 3) begin
                check("hold_x_before_commit", bif.obj_x, x0);
                check("hold_y_before_commit", bif.obj_y, y0);
            end
            if (i == 4) begin
                b = bif.bounce;
                c = bif.corner;
            end
            if (i == 5) check("bounce_pulse_width", bif.bounce, 0);
        end
        if (!p) n_model++;
        fc_model++;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic b;
        logic c;
        int   bcount;
        int   ex;
        int   ey;
        logic hx;
        logic hy;
        logic rp;

        tbl[0] = '{1'b0,   3, 310, 227,   3, 0, 1'b0, 1'b0};
        tbl[1] = '{1'b1,   5, 310, 227,   8, 0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 149, 608, 376, 157, 1, 1'b1, 1'b0};
        tbl[3] = '{1'b0,   1, 606, 377, 158, 0, 1'b0, 1'b0};
        tbl[4] = '{1'b0,  71, 464, 448, 229, 1, 1'b1, 1'b0};
        tbl[5] = '{1'b0,   1, 462, 447, 230, 0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 231,   0, 216, 461, 1, 1'b1, 1'b0};
        tbl[7] = '{1'b0,   1,   2, 215, 462, 0, 1'b0, 1'b0};

        // Reset values, then release with VSYNC already asserted.
        rst       = 1'b1;
        bif.VSYNC = 1'b1;
        bif.pause = 1'b0;
        cif.VSYNC = 1'b1;
        cif.pause = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_obj_x", bif.obj_x, 304);
        check("reset_obj_y", bif.obj_y, 224);
        check("reset_frame_count", bif.frame_count, 0);
        check("reset_bounce", bif.bounce, 0);
        check("reset_corner", bif.corner, 0);
        bif.VSYNC = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("no_tick_on_release_fc", bif.frame_count, 0);
        check("no_tick_on_release_x", bif.obj_x, 304);
        bif.VSYNC = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven frame groups.
        for (int r = 0; r < 8; r++) begin
            bcount = 0;
            for (int f = 0; f < tbl[r].frames; f++) begin
                run_frame(tbl[r].p, 2, 6, b, c);
                bcount += int'(b);
            end
            check("tbl_obj_x", bif.obj_x, tbl[r].ex);
            check("tbl_obj_y", bif.obj_y, tbl[r].ey);
            check("tbl_frame_count", bif.frame_count, tbl[r].efc);
            check("tbl_bounce_count", bcount, tbl[r].ebounces);
            check("tbl_last_bounce", b, tbl[r].eb);
            check("tbl_last_corner", c, tbl[r].ec);
        end

        // Randomized frames against the triangle-wave model.
        for (int k = 0; k < 500; k++) begin
            rp = ($urandom_range(0, 3) == 0);
            run_frame(rp, $urandom_range(1, 3), $urandom_range(5, 9), b, c);
            ex = tri_pos(304, 2, 608, n_model);
            ey = tri_pos(224, 1, 448, n_model);
            hx = !rp && (ex == 0 || ex == 608);
            hy = !rp && (ey == 0 || ey == 448);
            check("rand_obj_x", bif.obj_x, ex);
            check("rand_obj_y", bif.obj_y, ey);
            check("rand_frame_count", bif.frame_count, fc_model & 32'hFFFF);
            check("rand_bounce", b, hx | hy);
            check("rand_corner", c, hx & hy);
        end

        // Corner: second instance starts at x=608 moving right, y=447 moving down.
        for (int fr = 0; fr < 2; fr++) begin
            @(negedge clk);
            cif.VSYNC = 1'b0;
            for (int i = 1; i <= 8; i++) begin
                @(negedge clk);
                if (i == 2) cif.VSYNC = 1'b1;
                if (i == 3 && fr == 0) check("corner_hold_y", cif.obj_y, 447);
                if (i == 4) begin
                    check("corner_obj_x", cif.obj_x, (fr == 0) ? 608 : 606);
                    check("corner_obj_y", cif.obj_y, (fr == 0) ? 448 : 447);
                    check("corner_bounce", cif.bounce, (fr == 0) ? 1 : 0);
                    check("corner_corner", cif.corner, (fr == 0) ? 1 : 0);
                end
                if (i == 5) check("corner_pulse_width", cif.corner, 0);
            end
        end

        // Reset asserted while the FSM is in UPD_X.
        @(negedge clk);
        bif.VSYNC = 1'b0;
        bif.pause = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_obj_x", bif.obj_x, 304);
        check("midreset_obj_y", bif.obj_y, 224);
        check("midreset_frame_count", bif.frame_count, 0);
        bif.VSYNC = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_model  = 0;
        fc_model = 0;
        repeat (3) @(negedge clk);
        run_frame(1'b0, 2, 6, b, c);
        check("post_reset_obj_x", bif.obj_x, 306);
        check("post_reset_obj_y", bif.obj_y, 225);
        check("post_reset_frame_count", bif.frame_count, 1);
        check("post_reset_bounce", b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
